// File: rtl/regfile_2r1w.sv
// Parametrised 2-read / 1-write register file with registered read ports,
// same-edge write-to-read bypass, optional hardwired zero register.
module regfile_2r1w #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int ZERO_REG   = 0,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0] LP_NUM = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_sel1;
  logic [DATA_W-1:0] w_sel2;

  // Address refers to a real, writable register (in range and not the zero reg).
  function automatic logic f_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < LP_NUM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wr_ok = wr_en && f_live(wr_addr);

  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    if (f_live(rd_addr1))
      w_sel1 = (w_wr_ok && (wr_addr == rd_addr1)) ? wr_data : r_mem[rd_addr1];
    if (f_live(rd_addr2))
      w_sel2 = (w_wr_ok && (wr_addr == rd_addr2)) ? wr_data : r_mem[rd_addr2];
  end

  // Register 0 resets to 0 either way, so the zero register needs no special case here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_mem[ADDR_W'(i)] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data1 <= w_sel1;
        rd_data2 <= w_sel2;
      end
    end
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file that replaces the fixed 4-entry, 32-bit combinational register-select mux used on the register-read path.
- Holds NUM_REGS words of DATA_W bits.
- Provides two independent registered read ports and one synchronous write port.
- Supports write-to-read bypass, an optional hardwired zero register, and index-valued reset contents.
- Sits between instruction decode (addresses) and the ALU operand latches.

Parameters:
- NUM_REGS, 8, number of registers; minimum 2; need not be a power of two.
- DATA_W, 32, register width in bits.
- ADDR_W, $clog2(NUM_REGS), address width; derived, not overridden.
- ZERO_REG, 0, when 1, register 0 reads as 0 and ignores writes.
- INIT_INDEX, 1, when 1, reset loads register i with value i (zero-extended to DATA_W); when 0, reset loads 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rd_en  input  1  read strobe for both ports.
- rd_addr1  input  ADDR_W  read port 1 register number.
- rd_addr2  input  ADDR_W  read port 2 register number.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write register number.
- wr_data  input  DATA_W  write data.
- rd_data1  output  DATA_W  registered read data, port 1.
- rd_data2  output  DATA_W  registered read data, port 2.
- rd_valid  output  1  high for exactly the cycle after each accepted rd_en.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-high.
- While reset is high:
  - register i = (INIT_INDEX ? i : 0), and register 0 = 0 when ZERO_REG=1;
  - rd_data1 = 0, rd_data2 = 0, rd_valid = 0.
- Reset asserted mid-operation discards any write or read in the same cycle. The first edge after deassertion behaves normally.
- Write:
  - On a rising edge with wr_en=1, mem[wr_addr] <= wr_data.
  - The write is ignored if wr_addr >= NUM_REGS, or if ZERO_REG=1 and wr_addr=0.
- Read:
  - On a rising edge with rd_en=1, rd_dataN <= sel(rd_addrN) and rd_valid <= 1.
  - sel(a) = 0 if a >= NUM_REGS, or if ZERO_REG=1 and a=0.
  - Otherwise, if wr_en=1, wr_addr=a and the write is legal, sel(a) = wr_data (bypass).
  - Otherwise sel(a) = mem[a].
- Latency: read data appears one cycle after rd_en is sampled. A write is visible to a read issued on the same edge through the bypass, and to all later reads from the array.
- With rd_en=0: rd_data1 and rd_data2 hold their previous values; rd_valid <= 0.
- Ports 1 and 2 are fully independent. The same address on both ports returns identical data, including the bypass case.
- Back-to-back reads (rd_en held high) give a new result and rd_valid=1 every cycle.
- Simultaneous write and reads to different addresses: reads return the pre-write array contents.
- No combinational path from inputs to outputs. All outputs come straight from flops.

Test Plan:
- Reset contents (NUM_REGS=4, DATA_W=32, INIT_INDEX=1): pulse reset, then read addresses 0/1, then 2/3 -> rd_data1/rd_data2 = 0/1, then 2/3; rd_valid high one cycle after each rd_en. Output registers are 0 during reset.
- Write then read: write 0xDEADBEEF to reg 5 (NUM_REGS=8), then next cycle rd_addr1=5, rd_addr2=5 -> both ports = 0xDEADBEEF.
- Bypass: same edge wr_en=1, wr_addr=3, wr_data=0x12345678, rd_en=1, rd_addr1=3, rd_addr2=2 -> rd_data1 = 0x12345678, rd_data2 = 2 (reset value).
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 with a same-edge read of reg 0 -> rd_data1 = 0 then and on every later read. A write to reg 1 still succeeds.
- Out of range (NUM_REGS=6, ADDR_W=3): write 0xAAAA to address 7, read addresses 7 and 5 -> rd_data1 = 0, rd_data2 = 5. No register is changed.
- Hold and async reset: read reg 2 (= 2), then rd_en=0 for 3 cycles -> rd_data1 stays 2 and rd_valid=0. Assert reset between clock edges -> rd_data1 = 0 immediately. A prior write of 0x99 to reg 4 reads back as 4 after reset.
